// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: FSM state
// encoding, instruction field constants and datapath mux encodings.
package multicycle_control_pkg;

  // Controller states. Encodings 12..15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  // ALU operation class requested by the FSM; the ALU decoder turns it
  // into a concrete ALUSel. ALUOP_NONE yields the all-zero select used
  // in states that do not care about the ALU.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_NONE  = 2'b11
  } alu_op_e;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUSel encodings
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for every opcode the controller knows how to sequence.
  function automatic logic is_supported_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_alu_decoder.sv
// ALU select decoder: maps the FSM's ALU operation class plus the R-type
// function field onto the ALU's 3-bit operation select.
module multicycle_alu_decoder
  import multicycle_control_pkg::*;
(
  input  alu_op_e     alu_op_i,
  input  logic [5:0]  funct_i,
  output logic [2:0]  alu_sel_o
);

  // Unknown function codes fall back to add rather than flagging an error.
  always_comb begin
    alu_sel_o = ALU_AND;
    case (alu_op_i)
      ALUOP_ADD:  alu_sel_o = ALU_ADD;
      ALUOP_SUB:  alu_sel_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_sel_o = ALU_ADD;
          FN_SUB:  alu_sel_o = ALU_SUB;
          FN_AND:  alu_sel_o = ALU_AND;
          FN_OR:   alu_sel_o = ALU_OR;
          FN_SLT:  alu_sel_o = ALU_SLT;
          default: alu_sel_o = ALU_ADD;
        endcase
      end
      default:    alu_sel_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller. A Moore FSM walks each instruction through
// fetch, decode and 1-3 execution states, driving the shared-memory
// datapath's enables and mux selects. FETCH/MEMREAD/MEMWRITE stall on the
// memory handshake when MEM_WAIT_EN is set.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       PCWE,
  output logic       Branch,
  output logic       IorD,
  output logic       DMWE,
  output logic       IRWE,
  output logic       MtoRFSel,
  output logic       RFDSel,
  output logic       RFWE,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUSel,
  output logic [1:0] PCSrc,
  output logic       Jump,
  output logic       illegal_op
);

  state_e  state_q, state_d;
  logic    illegal_q, illegal_d;
  logic    ready;
  alu_op_e alu_op;

  // Raw enables before the reset gate.
  logic pcwe_c, branch_c, dmwe_c, irwe_c, rfwe_c;

  // With waiting disabled every access is assumed to complete at once.
  assign ready = (MEM_WAIT_EN == 0) ? 1'b1 : mem_ready;

  // State and illegal-opcode pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    pcwe_c    = 1'b0;
    branch_c  = 1'b0;
    dmwe_c    = 1'b0;
    irwe_c    = 1'b0;
    rfwe_c    = 1'b0;
    IorD      = 1'b0;
    MtoRFSel  = 1'b0;
    RFDSel    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    PCSrc     = PCSRC_ALU;
    Jump      = 1'b0;
    alu_op    = ALUOP_NONE;

    case (state_q)
      S_FETCH: begin
        // PC+4 computed while the instruction is read; both writes wait
        // for the memory to deliver.
        IorD    = 1'b0;
        ALUSrcA = 1'b0;
        ALUSrcB = SRCB_FOUR;
        alu_op  = ALUOP_ADD;
        PCSrc   = PCSRC_ALU;
        pcwe_c  = ready;
        irwe_c  = ready;
        state_d = ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        ALUSrcA = 1'b0;
        ALUSrcB = SRCB_IMM_SH;
        alu_op  = ALUOP_ADD;
        case (OpCode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_ADD;
        if (OpCode == OP_LW) begin
          state_d = S_MEMREAD;
        end else if (OpCode == OP_SW) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEMREAD: begin
        IorD    = 1'b1;
        state_d = ready ? S_MEMWB : S_MEMREAD;
      end

      S_MEMWB: begin
        RFDSel   = 1'b0;
        MtoRFSel = 1'b1;
        rfwe_c   = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEMWRITE: begin
        // Write strobe is held for the whole access, including waits.
        IorD    = 1'b1;
        dmwe_c  = 1'b1;
        state_d = ready ? S_FETCH : S_MEMWRITE;
      end

      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REG;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end

      S_ALUWB: begin
        RFDSel   = 1'b1;
        MtoRFSel = 1'b0;
        rfwe_c   = 1'b1;
        state_d  = S_FETCH;
      end

      S_BRANCH: begin
        // Compare by subtraction; the datapath qualifies Branch with Zero.
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_REG;
        alu_op   = ALUOP_SUB;
        branch_c = 1'b1;
        PCSrc    = PCSRC_ALUOUT;
        state_d  = S_FETCH;
      end

      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_ADD;
        state_d = S_ADDIWB;
      end

      S_ADDIWB: begin
        RFDSel   = 1'b0;
        MtoRFSel = 1'b0;
        rfwe_c   = 1'b1;
        state_d  = S_FETCH;
      end

      S_JUMP: begin
        pcwe_c  = 1'b1;
        PCSrc   = PCSRC_JUMP;
        Jump    = 1'b1;
        state_d = S_FETCH;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset suppresses every write so an aborted instruction leaves no trace.
  assign PCWE       = pcwe_c   & ~rst;
  assign IRWE       = irwe_c   & ~rst;
  assign DMWE       = dmwe_c   & ~rst;
  assign RFWE       = rfwe_c   & ~rst;
  assign Branch     = branch_c & ~rst;
  assign illegal_op = illegal_q;

  multicycle_alu_decoder u_alu_dec (
    .alu_op_i  (alu_op),
    .funct_i   (Funct),
    .alu_sel_o (ALUSel)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for the multi-cycle controller. Each instruction is
// expanded into its phase sequence (with memory waits and optional reset
// abort); the expected control vector of every cycle is queued and a
// negedge monitor compares it against the DUT outputs.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OpCode, Funct;
  logic       mem_ready;
  logic       PCWE, Branch, IorD, DMWE, IRWE, MtoRFSel, RFDSel, RFWE, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUSel;
  logic       Jump, illegal_op;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT_EN(1)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
    .PCWE(PCWE), .Branch(Branch), .IorD(IorD), .DMWE(DMWE), .IRWE(IRWE),
    .MtoRFSel(MtoRFSel), .RFDSel(RFDSel), .RFWE(RFWE), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUSel(ALUSel), .PCSrc(PCSrc), .Jump(Jump),
    .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic       pcwe, branch, iord, dmwe, irwe, mtorf, rfdsel, rfwe, srca;
    logic [1:0] srcb;
    logic [2:0] alusel;
    logic [1:0] pcsrc;
    logic       jump, illegal;
  } ctl_t;

  typedef struct {
    ctl_t v;
    logic in_rst;
    int   tag;
  } exp_t;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                P_EXEC, P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP} phase_e;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   pend_illegal = 1'b0;

  // ALU operation an R-type function code asks for.
  function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected controls for one cycle of a phase; unspecified fields are 0.
  function automatic ctl_t expect_phase(input phase_e ph, input logic rdy,
                                        input logic [5:0] fn);
    ctl_t c;
    c = '0;
    case (ph)
      P_FETCH:    begin c.srcb = 2'b01; c.alusel = 3'b010; c.pcwe = rdy; c.irwe = rdy; end
      P_DECODE:   begin c.srcb = 2'b11; c.alusel = 3'b010; end
      P_MEMADR:   begin c.srca = 1; c.srcb = 2'b10; c.alusel = 3'b010; end
      P_MEMREAD:  begin c.iord = 1; end
      P_MEMWB:    begin c.mtorf = 1; c.rfwe = 1; end
      P_MEMWRITE: begin c.iord = 1; c.dmwe = 1; end
      P_EXEC:     begin c.srca = 1; c.alusel = alu_for_funct(fn); end
      P_ALUWB:    begin c.rfdsel = 1; c.rfwe = 1; end
      P_BRANCH:   begin c.srca = 1; c.alusel = 3'b110; c.branch = 1; c.pcsrc = 2'b01; end
      P_ADDIEX:   begin c.srca = 1; c.srcb = 2'b10; c.alusel = 3'b010; end
      P_ADDIWB:   begin c.rfwe = 1; end
      P_JUMP:     begin c.pcwe = 1; c.pcsrc = 2'b10; c.jump = 1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Apply one cycle of inputs just after the edge and queue its expectation.
  task automatic drive(input logic r, input logic rdy, input logic [5:0] op,
                       input logic [5:0] fn, input ctl_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; mem_ready = rdy; OpCode = op; Funct = fn;
    e.v = v; e.in_rst = r; e.tag = cyc;
    sb.push_back(e);
    cyc++;
  endtask

  // Run one instruction: fw fetch waits, mw memory waits; abort >= 0 replaces
  // that cycle of the instruction with a reset pulse lasting rst_len cycles.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input int abort,
                           input int rst_len);
    phase_e ph[$];
    logic   rd[$];
    bit     illegal;
    ctl_t   v;
    illegal = 1'b0;
    for (int i = 0; i < fw; i++) begin ph.push_back(P_FETCH); rd.push_back(1'b0); end
    ph.push_back(P_FETCH);  rd.push_back(1'b1);
    ph.push_back(P_DECODE); rd.push_back(1'($urandom));
    case (op)
      6'b100011: begin
        ph.push_back(P_MEMADR); rd.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin ph.push_back(P_MEMREAD); rd.push_back(1'b0); end
        ph.push_back(P_MEMREAD); rd.push_back(1'b1);
        ph.push_back(P_MEMWB);   rd.push_back(1'($urandom));
      end
      6'b101011: begin
        ph.push_back(P_MEMADR); rd.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin ph.push_back(P_MEMWRITE); rd.push_back(1'b0); end
        ph.push_back(P_MEMWRITE); rd.push_back(1'b1);
      end
      6'b000000: begin
        ph.push_back(P_EXEC);  rd.push_back(1'($urandom));
        ph.push_back(P_ALUWB); rd.push_back(1'($urandom));
      end
      6'b000100: begin ph.push_back(P_BRANCH); rd.push_back(1'($urandom)); end
      6'b001000: begin
        ph.push_back(P_ADDIEX); rd.push_back(1'($urandom));
        ph.push_back(P_ADDIWB); rd.push_back(1'($urandom));
      end
      6'b000010: begin ph.push_back(P_JUMP); rd.push_back(1'($urandom)); end
      default:   illegal = 1'b1;
    endcase
    for (int i = 0; i < ph.size(); i++) begin
      if (i == abort) begin
        for (int k = 0; k < rst_len; k++)
          drive(1'b1, 1'($urandom), 6'($urandom), 6'($urandom), '0);
        pend_illegal = 1'b0;
        $display("instr op=%b fn=%b aborted by reset at cycle %0d of %0d",
                 op, fn, i + 1, ph.size());
        return;
      end
      v = expect_phase(ph[i], rd[i], fn);
      v.illegal = pend_illegal;
      pend_illegal = 1'b0;
      if (ph[i] == P_FETCH)
        drive(1'b0, rd[i], 6'($urandom), 6'($urandom), v);
      else
        drive(1'b0, rd[i], op, fn, v);
    end
    pend_illegal = illegal;
    $display("instr op=%b fn=%b fetch_wait=%0d mem_wait=%0d cycles=%0d%s",
             op, fn, fw, mw, ph.size(), illegal ? " illegal" : "");
  endtask

  // Monitor: compare every queued cycle on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    ctl_t act;
    logic [17:0] rmask;
    bit ok;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act = {PCWE, Branch, IorD, DMWE, IRWE, MtoRFSel, RFDSel, RFWE, ALUSrcA,
             ALUSrcB, ALUSel, PCSrc, Jump, illegal_op};
      rmask = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'b0};
      if (e.in_rst) ok = ((18'(act) & rmask) == 18'b0);
      else          ok = (18'(act) === 18'(e.v));
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL cyc%0d %s actual=%h required=%h", e.tag,
                 e.in_rst ? "reset_enables" : "ctl", 18'(act),
                 e.in_rst ? 18'b0 : 18'(e.v));
      end
    end
  end

  logic [5:0] ops [7];
  logic [5:0] fns [6];

  initial begin
    int k, f, ab, wait_n;
    logic [5:0] bad_op;
    rst = 1'b1; mem_ready = 1'b0; OpCode = '0; Funct = '0;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011011};

    // Power-on reset for two cycles.
    drive(1'b1, 1'b0, 6'd0, 6'd0, '0);
    drive(1'b1, 1'b0, 6'd0, 6'd0, '0);

    // Directed sequences.
    run_instr(6'b000000, 6'b100000, 0, 0, -1, 0);  // add
    run_instr(6'b100011, 6'b000000, 0, 2, -1, 0);  // lw, two read waits
    run_instr(6'b101011, 6'b000000, 0, 0, -1, 0);  // sw
    run_instr(6'b000100, 6'b000000, 0, 0, -1, 0);  // beq
    run_instr(6'b000010, 6'b000000, 0, 0, -1, 0);  // j
    run_instr(6'b111111, 6'b000000, 0, 0, -1, 0);  // illegal
    run_instr(6'b001000, 6'b000000, 1, 0, -1, 0);  // addi, shows illegal pulse
    run_instr(6'b101011, 6'b000000, 0, 2, 4, 1);   // sw reset during write wait
    run_instr(6'b000000, 6'b101010, 2, 0, -1, 0);  // slt after fetch waits

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 6);
      f = $urandom_range(0, 5);
      bad_op = ops[k];
      if (k == 6) begin
        bad_op = 6'($urandom);
        while (bad_op == 6'b000000 || bad_op == 6'b100011 || bad_op == 6'b101011 ||
               bad_op == 6'b000100 || bad_op == 6'b001000 || bad_op == 6'b000010)
          bad_op = 6'($urandom);
      end
      wait_n = $urandom_range(0, 2);
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1;
      run_instr(bad_op, (f == 5) ? 6'($urandom) : fns[f], $urandom_range(0, 2),
                wait_n, ab, $urandom_range(1, 2));
    end
    run_instr(6'b000000, 6'b100000, 0, 0, -1, 0);

    // Let the monitor drain, then confirm nothing was left unchecked.
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
